// File: rtl/id_stage_bp.sv
// id_stage_bp: registered MIPS decode stage with register bank and 2-bit BHT branch predictor
module id_stage_bp #(
    parameter int         DATA_W    = 32,
    parameter int         NUM_REGS  = 32,
    parameter int         BHT_DEPTH = 64,
    parameter logic [1:0] BHT_INIT  = 2'b01
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [31:0]       i_next_pc,
    input  logic [31:0]       i_instruction,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic              i_reg_write,
    input  logic [4:0]        i_write_register,
    input  logic [DATA_W-1:0] i_write_data,
    input  logic              i_bp_update,
    input  logic [31:0]       i_bp_update_pc,
    input  logic              i_bp_taken,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_read_data_1,
    output logic [DATA_W-1:0] o_read_data_2,
    output logic [31:0]       o_sign_extended_imm,
    output logic [4:0]        o_rs,
    output logic [4:0]        o_rt,
    output logic [4:0]        o_rd,
    output logic [4:0]        o_shamt,
    output logic [5:0]        o_function,
    output logic [5:0]        o_opcode,
    output logic              o_alu_src,
    output logic              o_reg_dst,
    output logic              o_reg_write,
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic              o_mem_to_reg,
    output logic              o_branch,
    output logic [1:0]        o_alu_op,
    output logic              o_jump,
    output logic              o_branch_prediction,
    output logic [31:0]       o_branch_target_addr
);
    localparam int BIDX_W = $clog2(BHT_DEPTH);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [31:0]       imm;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [4:0]        shamt;
        logic [5:0]        funct;
        logic [5:0]        opcode;
        logic              alu_src;
        logic              reg_dst;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              branch;
        logic [1:0]        alu_op;
        logic              jump;
        logic              pred;
        logic [31:0]       target;
    } idex_t;

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [1:0]        r_bht  [BHT_DEPTH];
    idex_t             r_q;
    idex_t             w_next;

    logic [5:0]        w_op;
    logic [4:0]        w_rs, w_rt;
    logic [31:0]       w_imm;
    logic              w_is_r, w_is_lw, w_is_sw, w_is_br, w_is_addi, w_is_j, w_is_jal, w_jump;
    logic              w_byp_rs, w_byp_rt;
    logic [BIDX_W-1:0] w_idx, w_uidx;
    logic [1:0]        w_cnt;
    logic              w_unused;

    assign w_op      = i_instruction[31:26];
    assign w_rs      = i_instruction[25:21];
    assign w_rt      = i_instruction[20:16];
    assign w_imm     = {{16{i_instruction[15]}}, i_instruction[15:0]};
    assign w_is_r    = w_op == 6'h00;
    assign w_is_lw   = w_op == 6'h23;
    assign w_is_sw   = w_op == 6'h2b;
    assign w_is_br   = w_op == 6'h04 || w_op == 6'h05;
    assign w_is_addi = w_op == 6'h08;
    assign w_is_j    = w_op == 6'h02;
    assign w_is_jal  = w_op == 6'h03;
    assign w_jump    = w_is_j || w_is_jal;
    assign w_byp_rs  = i_reg_write && i_write_register != '0 && i_write_register == w_rs;
    assign w_byp_rt  = i_reg_write && i_write_register != '0 && i_write_register == w_rt;
    // index of PC = next_pc - 4, taken directly from the PC+4 bits
    assign w_idx     = i_next_pc[BIDX_W+1:2] - BIDX_W'(1);
    assign w_uidx    = i_bp_update_pc[BIDX_W+1:2];
    assign w_cnt     = r_bht[w_uidx];
    assign w_unused  = ^{i_bp_update_pc[31:BIDX_W+2], i_bp_update_pc[1:0]};

    always_comb begin
        w_next            = '0;
        w_next.valid      = i_valid;
        w_next.rd1        = w_byp_rs ? i_write_data : r_regs[w_rs];
        w_next.rd2        = w_byp_rt ? i_write_data : r_regs[w_rt];
        w_next.imm        = w_imm;
        w_next.rs         = w_rs;
        w_next.rt         = w_rt;
        w_next.rd         = i_instruction[15:11];
        w_next.shamt      = i_instruction[10:6];
        w_next.funct      = i_instruction[5:0];
        w_next.opcode     = w_op;
        w_next.alu_src    = i_valid && (w_is_lw || w_is_sw || w_is_addi);
        w_next.reg_dst    = i_valid && w_is_r;
        w_next.reg_write  = i_valid && (w_is_r || w_is_lw || w_is_addi || w_is_jal);
        w_next.mem_read   = i_valid && w_is_lw;
        w_next.mem_write  = i_valid && w_is_sw;
        w_next.mem_to_reg = i_valid && w_is_lw;
        w_next.branch     = i_valid && w_is_br;
        w_next.alu_op     = !i_valid ? 2'b00 : w_is_r ? 2'b10 : w_is_br ? 2'b01 : 2'b00;
        w_next.jump       = i_valid && w_jump;
        w_next.pred       = i_valid && (w_is_br ? r_bht[w_idx][1] : w_jump);
        w_next.target     = w_jump ? {i_next_pc[31:28], i_instruction[25:0], 2'b00}
                                   : i_next_pc + {w_imm[29:0], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (!reset)
            r_q <= '0;
        else if (i_flush)
            r_q <= '0;
        else if (!i_stall)
            r_q <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        else if (i_reg_write && i_write_register != '0)
            r_regs[i_write_register] <= i_write_data;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= BHT_INIT;
        else if (i_bp_update)
            r_bht[w_uidx] <= i_bp_taken ? (w_cnt == 2'd3 ? w_cnt : w_cnt + 2'd1)
                                        : (w_cnt == 2'd0 ? w_cnt : w_cnt - 2'd1);
    end

    assign o_valid              = r_q.valid;
    assign o_read_data_1        = r_q.rd1;
    assign o_read_data_2        = r_q.rd2;
    assign o_sign_extended_imm  = r_q.imm;
    assign o_rs                 = r_q.rs;
    assign o_rt                 = r_q.rt;
    assign o_rd                 = r_q.rd;
    assign o_shamt              = r_q.shamt;
    assign o_function           = r_q.funct;
    assign o_opcode             = r_q.opcode;
    assign o_alu_src            = r_q.alu_src;
    assign o_reg_dst            = r_q.reg_dst;
    assign o_reg_write          = r_q.reg_write;
    assign o_mem_read           = r_q.mem_read;
    assign o_mem_write          = r_q.mem_write;
    assign o_mem_to_reg         = r_q.mem_to_reg;
    assign o_branch             = r_q.branch;
    assign o_alu_op             = r_q.alu_op;
    assign o_jump               = r_q.jump;
    assign o_branch_prediction  = r_q.pred;
    assign o_branch_target_addr = r_q.target;
endmodule

// File: tb/tb_id_stage_bp.sv
// tb_id_stage_bp: directed and randomized checks of id_stage_bp against a behavioural model
module tb_id_stage_bp;
    logic        clk = 1'b0;
    logic        reset, i_valid, i_stall, i_flush, i_reg_write, i_bp_update, i_bp_taken;
    logic [31:0] i_next_pc, i_instruction, i_write_data, i_bp_update_pc;
    logic [4:0]  i_write_register;
    logic        o_valid, o_alu_src, o_reg_dst, o_reg_write, o_mem_read, o_mem_write;
    logic        o_mem_to_reg, o_branch, o_jump, o_branch_prediction;
    logic [31:0] o_read_data_1, o_read_data_2, o_sign_extended_imm, o_branch_target_addr;
    logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
    logic [5:0]  o_function, o_opcode;
    logic [1:0]  o_alu_op;

    always #5 clk = ~clk;

    id_stage_bp dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .i_next_pc(i_next_pc),
        .i_instruction(i_instruction), .i_stall(i_stall), .i_flush(i_flush),
        .i_reg_write(i_reg_write), .i_write_register(i_write_register),
        .i_write_data(i_write_data), .i_bp_update(i_bp_update),
        .i_bp_update_pc(i_bp_update_pc), .i_bp_taken(i_bp_taken),
        .o_valid(o_valid), .o_read_data_1(o_read_data_1), .o_read_data_2(o_read_data_2),
        .o_sign_extended_imm(o_sign_extended_imm), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
        .o_shamt(o_shamt), .o_function(o_function), .o_opcode(o_opcode),
        .o_alu_src(o_alu_src), .o_reg_dst(o_reg_dst), .o_reg_write(o_reg_write),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_mem_to_reg(o_mem_to_reg),
        .o_branch(o_branch), .o_alu_op(o_alu_op), .o_jump(o_jump),
        .o_branch_prediction(o_branch_prediction), .o_branch_target_addr(o_branch_target_addr)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    logic [31:0] m_regs [32];
    int          m_bht  [64];
    logic        e_valid;
    logic [31:0] e_rd1, e_rd2, e_imm, e_fields, e_tgt;
    logic [10:0] e_ctl;

    function automatic logic [31:0] rdval(input logic [4:0] r);
        if (r == 0) return 32'h0;
        if (i_reg_write && i_write_register == r) return i_write_data;
        return m_regs[r];
    endfunction

    task automatic model_eval();
        logic [5:0]  op;
        logic [31:0] imm, pc;
        logic        asrc, rdst, rw, mr, mw, m2r, br, jmp, pred;
        logic [1:0]  aop;
        int          idx;
        if (!reset || i_flush) begin
            e_valid = 0; e_rd1 = 0; e_rd2 = 0; e_imm = 0; e_fields = 0; e_tgt = 0; e_ctl = 0;
        end else if (!i_stall) begin
            op  = i_instruction[31:26];
            imm = {{16{i_instruction[15]}}, i_instruction[15:0]};
            {asrc, rdst, rw, mr, mw, m2r, br, jmp} = '0;
            aop = 2'b00;
            case (op)
                6'h00: begin rdst = 1; rw = 1; aop = 2'b10; end
                6'h23: begin asrc = 1; rw = 1; mr = 1; m2r = 1; end
                6'h2b: begin asrc = 1; mw = 1; end
                6'h04, 6'h05: begin br = 1; aop = 2'b01; end
                6'h08: begin asrc = 1; rw = 1; end
                6'h02: jmp = 1;
                6'h03: begin jmp = 1; rw = 1; end
                default: ;
            endcase
            pc   = i_next_pc - 32'd4;
            idx  = int'((pc >> 2) % 64);
            pred = br ? (m_bht[idx] >= 2) : jmp;
            e_tgt = jmp ? ((i_next_pc & 32'hF000_0000) | ({6'b0, i_instruction[25:0]} << 2))
                        : i_next_pc + imm * 32'd4;
            e_valid  = i_valid;
            e_ctl    = i_valid ? {asrc, rdst, rw, mr, mw, m2r, br, aop, jmp, pred} : 11'b0;
            e_rd1    = rdval(i_instruction[25:21]);
            e_rd2    = rdval(i_instruction[20:16]);
            e_imm    = imm;
            e_fields = {i_instruction[25:0], op};
        end
    endtask

    task automatic model_update();
        int idx;
        if (!reset) begin
            for (int k = 0; k < 32; k++) m_regs[k] = 0;
            for (int k = 0; k < 64; k++) m_bht[k] = 1;
        end else begin
            if (i_reg_write && i_write_register != 0) m_regs[i_write_register] = i_write_data;
            if (i_bp_update) begin
                idx = int'((i_bp_update_pc >> 2) % 64);
                m_bht[idx] = i_bp_taken ? (m_bht[idx] == 3 ? 3 : m_bht[idx] + 1)
                                        : (m_bht[idx] == 0 ? 0 : m_bht[idx] - 1);
            end
        end
    endtask

    task automatic step();
        model_eval();
        @(posedge clk);
        #1;
        check("valid", {31'b0, o_valid}, {31'b0, e_valid});
        check("rd1", o_read_data_1, e_rd1);
        check("rd2", o_read_data_2, e_rd2);
        check("imm", o_sign_extended_imm, e_imm);
        check("fields", {o_rs, o_rt, o_rd, o_shamt, o_function, o_opcode}, e_fields);
        check("ctl", {21'b0, o_alu_src, o_reg_dst, o_reg_write, o_mem_read, o_mem_write,
                      o_mem_to_reg, o_branch, o_alu_op, o_jump, o_branch_prediction},
              {21'b0, e_ctl});
        check("target", o_branch_target_addr, e_tgt);
        model_update();
    endtask

    task automatic idle();
        i_valid = 1; i_stall = 0; i_flush = 0; i_reg_write = 0; i_bp_update = 0;
        i_bp_taken = 0; i_write_register = 0; i_write_data = 0; i_bp_update_pc = 0;
        i_instruction = 0; i_next_pc = 32'h4;
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input int n);
        for (int k = 0; k < n; k++) begin
            idle();
            i_bp_update = 1; i_bp_update_pc = pc; i_bp_taken = taken;
            step();
        end
        i_bp_update = 0;
    endtask

    task automatic decode(input logic [31:0] instr, input logic [31:0] npc);
        i_instruction = instr; i_next_pc = npc;
        step();
    endtask

    localparam logic [31:0] ADD_R1_R5 = 32'h00A0_0820;
    localparam logic [31:0] ADD_R1_R0 = 32'h0000_0820;
    localparam logic [31:0] BEQ3      = 32'h1000_0003;
    localparam logic [31:0] BEQ_M1    = 32'h1000_FFFF;
    localparam logic [31:0] J40       = 32'h0800_0040;

    initial begin
        logic [5:0] ops [9];
        ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h02, 6'h03, 6'h0d};
        idle();
        reset = 0;
        step(); step();
        check("rst_valid", {31'b0, o_valid}, 32'h0);
        check("rst_tgt", o_branch_target_addr, 32'h0);
        reset = 1;
        step();
        check("post_rst_valid", {31'b0, o_valid}, 32'h1);
        decode(BEQ3, 32'h104);
        check("init_pred", {31'b0, o_branch_prediction}, 32'h0);
        check("beq_tgt", o_branch_target_addr, 32'h110);

        idle(); i_reg_write = 1; i_write_register = 5; i_write_data = 32'hDEADBEEF;
        step();
        idle(); decode(ADD_R1_R5, 32'h4);
        check("r5_read", o_read_data_1, 32'hDEADBEEF);
        idle(); i_reg_write = 1; i_write_register = 5; i_write_data = 32'h1111_2222;
        decode(ADD_R1_R5, 32'h4);
        check("bypass", o_read_data_1, 32'h1111_2222);
        idle(); i_reg_write = 1; i_write_register = 0; i_write_data = 32'h1234;
        decode(ADD_R1_R0, 32'h4);
        check("r0_byp", o_read_data_1, 32'h0);
        idle(); decode(ADD_R1_R0, 32'h4);
        check("r0_read", o_read_data_1, 32'h0);

        upd(32'h100, 1, 3);
        idle(); decode(BEQ3, 32'h104);
        check("trained_t", {31'b0, o_branch_prediction}, 32'h1);
        upd(32'h100, 0, 6);
        idle(); decode(BEQ3, 32'h104);
        check("trained_nt", {31'b0, o_branch_prediction}, 32'h0);
        upd(32'h100, 1, 1);
        idle(); decode(BEQ3, 32'h104);
        check("sat_low", {31'b0, o_branch_prediction}, 32'h0);
        upd(32'h100, 1, 1);
        idle(); decode(BEQ3, 32'h204);
        check("alias", {31'b0, o_branch_prediction}, 32'h1);
        upd(32'h100, 0, 1);
        idle(); i_bp_update = 1; i_bp_update_pc = 32'h100; i_bp_taken = 1;
        decode(BEQ3, 32'h104);
        check("collide_old", {31'b0, o_branch_prediction}, 32'h0);
        idle(); decode(BEQ3, 32'h104);
        check("collide_new", {31'b0, o_branch_prediction}, 32'h1);

        idle(); decode(J40, 32'h8000_0004);
        check("j_jump", {31'b0, o_jump}, 32'h1);
        check("j_pred", {31'b0, o_branch_prediction}, 32'h1);
        check("j_tgt", o_branch_target_addr, 32'h8000_0100);
        idle(); decode(BEQ_M1, 32'h8);
        check("neg_tgt", o_branch_target_addr, 32'h4);

        idle(); decode(32'h8C22_0010, 32'h40);
        for (int k = 0; k < 3; k++) begin
            i_stall = 1; i_instruction = $urandom; i_next_pc = $urandom;
            step();
            check("stall_op", {26'b0, o_opcode}, 32'h23);
        end
        idle(); i_stall = 1; i_flush = 1; decode(32'h8C22_0010, 32'h40);
        check("flush_valid", {31'b0, o_valid}, 32'h0);
        check("flush_rw", {31'b0, o_reg_write}, 32'h0);
        idle(); decode(ADD_R1_R5, 32'h4);
        i_stall = 1; reset = 0;
        step();
        check("rst_stall_rd1", o_read_data_1, 32'h0);
        check("rst_stall_valid", {31'b0, o_valid}, 32'h0);
        reset = 1;

        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 99) != 0);
            i_valid = ($urandom_range(0, 99) < 85);
            i_stall = ($urandom_range(0, 99) < 15);
            i_flush = ($urandom_range(0, 99) < 8);
            i_reg_write = $urandom_range(0, 1);
            i_write_register = 5'($urandom_range(0, 31));
            i_write_data = $urandom;
            i_bp_update = $urandom_range(0, 1);
            i_bp_taken = $urandom_range(0, 1);
            i_bp_update_pc = {$urandom_range(0, 255), 2'b00};
            i_instruction = {ops[$urandom_range(0, 8)], 26'($urandom)};
            i_next_pc = $urandom_range(0, 1) ? {$urandom_range(0, 255), 2'b00} + 32'd4
                                             : {30'($urandom), 2'b00};
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
